// File: rtl/ctrl_reg_pkg.sv
// rtl/ctrl_reg_pkg.sv - shared types and constants for the control register initiator
// Contents: FSM state enum, command header bit positions, register addresses,
// state-register encodings and a header reserved-bit check helper.
package ctrl_reg_pkg;

  typedef enum logic [2:0] {
    IDLE     = 3'd0,
    GET_DATA = 3'd1,
    WRITE    = 3'd2,
    READ     = 3'd3,
    RESP     = 3'd4
  } state_t;

  localparam int CMD_WRITE_BIT = 7;
  localparam int CMD_RSVD_MSB  = 6;
  localparam int CMD_RSVD_LSB  = 3;

  localparam logic [2:0] ADDR_PALETTE = 3'b000;
  localparam logic [2:0] ADDR_STATE   = 3'b001;

  localparam logic [7:0] STATE_NORMAL  = 8'd0;
  localparam logic [7:0] STATE_LOADING = 8'd1;
  localparam logic [7:0] STATE_BOOT    = 8'd2;

  // A header is malformed when any reserved bit is set.
  function automatic logic hdr_rsvd_err(input logic [7:0] hdr);
    return |hdr[CMD_RSVD_MSB:CMD_RSVD_LSB];
  endfunction

endpackage

// File: rtl/ctrl_timeout_counter.sv
// rtl/ctrl_timeout_counter.sv - wait-for-data timeout counter
// Ports:
//   clk, rst  : clock, synchronous active-high reset
//   clear     : force count to zero
//   enable    : advance count by one (stops at the last value)
//   expired   : count has reached TIMEOUT_CYCLES-1
module ctrl_timeout_counter #(
  parameter int TIMEOUT_CYCLES = 1024
) (
  input  logic clk,
  input  logic rst,
  input  logic clear,
  input  logic enable,
  output logic expired
);

  localparam int CW = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
  localparam logic [CW-1:0] LAST = CW'(TIMEOUT_CYCLES - 1);

  logic [CW-1:0] count;

  always_ff @(posedge clk) begin
    if (rst || clear) begin
      count <= '0;
    end else if (enable && !expired) begin
      count <= count + CW'(1);
    end
  end

  assign expired = (count == LAST);

endmodule

// File: rtl/ctrl_reg_initiator.sv
// rtl/ctrl_reg_initiator.sv - byte-stream to register read/write initiator
// Optional feature macro: CTRL_WRITE_ECHO_EN (read back and return every written register).
// Ports:
//   clk, rst                      : clock, synchronous active-high reset
//   cmd_data/cmd_valid/cmd_ready  : command byte stream from the bus bridge
//   rsp_data/rsp_valid/rsp_ready  : response byte stream to the bus bridge
//   reg_read_addr/reg_read_data   : register file read port (combinational data)
//   reg_write_addr/data/enable    : register file write port
//   err_count                     : saturating count of malformed headers and data timeouts
module ctrl_reg_initiator
  import ctrl_reg_pkg::*;
#(
  parameter int TIMEOUT_CYCLES = 1024,
  parameter int ADDR_W         = 3
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [7:0]        cmd_data,
  input  logic              cmd_valid,
  output logic              cmd_ready,
  output logic [7:0]        rsp_data,
  output logic              rsp_valid,
  input  logic              rsp_ready,
  output logic [ADDR_W-1:0] reg_read_addr,
  input  logic [7:0]        reg_read_data,
  output logic [ADDR_W-1:0] reg_write_addr,
  output logic [7:0]        reg_write_data,
  output logic              reg_write_enable,
  output logic [7:0]        err_count
);

  state_t state;
  state_t next_state;

  logic cmd_xfer;
  logic rsp_xfer;
  logic rsvd_err;
  logic hdr_ok;
  logic timeout_expired;
  logic timeout_hit;
  logic to_clear;
  logic to_enable;

  assign cmd_xfer    = cmd_valid && cmd_ready;
  assign rsp_xfer    = rsp_valid && rsp_ready;
  assign rsvd_err    = hdr_rsvd_err(cmd_data);
  assign hdr_ok      = (state == IDLE) && cmd_xfer && !rsvd_err;
  // A byte arriving on the last allowed cycle still wins over the timeout.
  assign timeout_hit = (state == GET_DATA) && !cmd_xfer && timeout_expired;

  ctrl_timeout_counter #(
    .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
  ) u_timeout (
    .clk    (clk),
    .rst    (rst),
    .clear  (to_clear),
    .enable (to_enable),
    .expired(timeout_expired)
  );

  always_comb begin
    next_state = state;
    to_clear   = 1'b1;
    to_enable  = 1'b0;
    case (state)
      IDLE: begin
        if (hdr_ok) begin
          next_state = cmd_data[CMD_WRITE_BIT] ? GET_DATA : READ;
        end
      end
      GET_DATA: begin
        to_clear = 1'b0;
        if (cmd_xfer) begin
          next_state = WRITE;
        end else if (timeout_expired) begin
          next_state = IDLE;
        end else begin
          to_enable = 1'b1;
        end
      end
      WRITE: begin
`ifdef CTRL_WRITE_ECHO_EN
        next_state = READ;
`else
        next_state = IDLE;
`endif
      end
      READ:    next_state = RESP;
      RESP:    if (rsp_xfer) next_state = IDLE;
      default: next_state = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state            <= IDLE;
      cmd_ready        <= 1'b0;
      rsp_valid        <= 1'b0;
      rsp_data         <= 8'd0;
      reg_read_addr    <= '0;
      reg_write_addr   <= '0;
      reg_write_data   <= 8'd0;
      reg_write_enable <= 1'b0;
      err_count        <= 8'd0;
    end else begin
      state            <= next_state;
      // Outputs are registered, so they are decoded from the state being entered.
      cmd_ready        <= (next_state == IDLE) || (next_state == GET_DATA);
      reg_write_enable <= (next_state == WRITE);
      rsp_valid        <= (next_state == RESP);

      if (hdr_ok) begin
        if (cmd_data[CMD_WRITE_BIT]) begin
          reg_write_addr <= cmd_data[ADDR_W-1:0];
        end else begin
          reg_read_addr  <= cmd_data[ADDR_W-1:0];
        end
      end

      if ((state == GET_DATA) && cmd_xfer) begin
        reg_write_data <= cmd_data;
`ifdef CTRL_WRITE_ECHO_EN
        reg_read_addr  <= reg_write_addr;
`endif
      end

      if (state == READ) begin
        rsp_data <= reg_read_data;
      end

      if ((((state == IDLE) && cmd_xfer && rsvd_err) || timeout_hit) && (err_count != 8'hFF)) begin
        err_count <= err_count + 8'd1;
      end
    end
  end

endmodule

// File: tb/tb_ctrl_reg_initiator.sv
// tb/tb_ctrl_reg_initiator.sv - self-checking bench for ctrl_reg_initiator
// Optional feature macro: CTRL_WRITE_ECHO_EN (bench follows the same build setting).
module tb_ctrl_reg_initiator;

  localparam int T = 8;
  localparam logic [7:0] INIT_REGS [8] = '{8'h11, 8'h22, 8'h33, 8'h44, 8'h55, 8'h66, 8'h77, 8'h88};

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [7:0] cmd_data = 8'd0;
  logic       cmd_valid = 1'b0;
  logic       cmd_ready;
  logic [7:0] rsp_data;
  logic       rsp_valid;
  logic       rsp_ready = 1'b0;
  logic [2:0] reg_read_addr;
  logic [7:0] reg_read_data;
  logic [2:0] reg_write_addr;
  logic [7:0] reg_write_data;
  logic       reg_write_enable;
  logic [7:0] err_count;

  int vectors = 0;
  int misses  = 0;

  ctrl_reg_initiator #(.TIMEOUT_CYCLES(T), .ADDR_W(3)) dut (
    .clk(clk), .rst(rst),
    .cmd_data(cmd_data), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
    .rsp_data(rsp_data), .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
    .reg_read_addr(reg_read_addr), .reg_read_data(reg_read_data),
    .reg_write_addr(reg_write_addr), .reg_write_data(reg_write_data),
    .reg_write_enable(reg_write_enable), .err_count(err_count)
  );

  always #5 clk = ~clk;

  // Attached register file (not reset by the initiator).
  logic [7:0] regs [8] = INIT_REGS;
  always @(posedge clk) if (reg_write_enable) regs[reg_write_addr] <= reg_write_data;
  assign reg_read_data = regs[reg_read_addr];

  task automatic chk(input string name, input logic [7:0] act, input logic [7:0] exp);
    vectors++;
    if (act !== exp) begin
      misses++;
      $display("FAIL %s at %0t: got %0h expected %0h", name, $time, act, exp);
    end
  endtask

  // Transaction-level reference: scheduled cycle numbers for the write pulse,
  // the read sample and the outstanding response.
  logic [7:0] shadow [8] = INIT_REGS;
  bit   model_valid = 0;
  int   cyc = 0;
  bit   waiting = 0;
  int   deadline = 0;
  int   we_cycle = -1;
  int   read_cycle = -1;
  logic       exp_ready = 0, exp_we = 0, exp_rsp_valid = 0;
  logic [2:0] exp_waddr = 0, exp_raddr = 0;
  logic [7:0] exp_wdata = 0, exp_rsp_data = 0, exp_err = 0;

  function automatic logic [7:0] bump(input logic [7:0] e);
    return (e == 8'hFF) ? e : e + 8'd1;
  endfunction

  always @(negedge clk) begin
    if (model_valid) begin
      chk("cmd_ready", cmd_ready, exp_ready);
      chk("rsp_valid", rsp_valid, exp_rsp_valid);
      chk("rsp_data", rsp_data, exp_rsp_data);
      chk("reg_write_enable", reg_write_enable, exp_we);
      chk("reg_write_addr", reg_write_addr, exp_waddr);
      chk("reg_write_data", reg_write_data, exp_wdata);
      chk("reg_read_addr", reg_read_addr, exp_raddr);
      chk("err_count", err_count, exp_err);
    end
    if (model_valid && exp_we) shadow[exp_waddr] = exp_wdata;
    if (rst) begin
      exp_ready = 0; exp_we = 0; exp_rsp_valid = 0; exp_waddr = 0; exp_raddr = 0;
      exp_wdata = 0; exp_rsp_data = 0; exp_err = 0;
      waiting = 0; we_cycle = -1; read_cycle = -1; model_valid = 1;
    end else if (model_valid) begin
      automatic bit xfer = cmd_valid && exp_ready;
      automatic bit rx   = exp_rsp_valid && rsp_ready;
      if (xfer && waiting) begin
        exp_wdata = cmd_data; waiting = 0; we_cycle = cyc + 1;
`ifdef CTRL_WRITE_ECHO_EN
        exp_raddr = exp_waddr; read_cycle = cyc + 2;
`endif
      end else if (xfer) begin
        if (cmd_data[6:3] != 4'd0) exp_err = bump(exp_err);
        else if (cmd_data[7]) begin exp_waddr = cmd_data[2:0]; waiting = 1; deadline = cyc + T; end
        else begin exp_raddr = cmd_data[2:0]; read_cycle = cyc + 1; end
      end else if (waiting && cyc == deadline) begin
        exp_err = bump(exp_err); waiting = 0;
      end
      if (read_cycle == cyc) begin exp_rsp_data = shadow[exp_raddr]; exp_rsp_valid = 1; end
      else if (rx) exp_rsp_valid = 0;
      exp_we    = (we_cycle == cyc + 1);
      exp_ready = !exp_we && (read_cycle != cyc + 1) && !exp_rsp_valid;
    end
    cyc++;
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic send_byte(input logic [7:0] b);
    int t = 0;
    cmd_data = b; cmd_valid = 1'b1;
    while (cmd_ready !== 1'b1 && t < 100) begin tick(); t++; end
    if (t >= 100) chk("send_wait_ready", 8'd0, 8'd1);
    tick();
    cmd_valid = 1'b0;
  endtask

  task automatic get_rsp(input string name, input logic [7:0] exp);
    int t = 0;
    while (rsp_valid !== 1'b1 && t < 50) begin tick(); t++; end
    chk("rsp_wait", rsp_valid, 8'd1);
    chk(name, rsp_data, exp);
    rsp_ready = 1'b1; tick(); rsp_ready = 1'b0;
  endtask

  // Write with literal checks on the pulse (and on the echo when built in).
  task automatic do_write(input logic [2:0] a, input logic [7:0] d);
    send_byte({1'b1, 4'b0, a});
    send_byte(d);
    chk("lit_we", reg_write_enable, 8'd1);
    chk("lit_waddr", reg_write_addr, {5'd0, a});
    chk("lit_wdata", reg_write_data, d);
`ifdef CTRL_WRITE_ECHO_EN
    tick(); tick();
    chk("lit_echo_valid_k3", rsp_valid, 8'd1);
    get_rsp("lit_echo_data", d);
`else
    tick(); tick();
    chk("lit_no_echo", rsp_valid, 8'd0);
`endif
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int pv = 50;
    // Reset state.
    repeat (3) tick();
    chk("lit_rst_ready", cmd_ready, 8'd0);
    chk("lit_rst_err", err_count, 8'd0);
    chk("lit_rst_we", reg_write_enable, 8'd0);
    rst = 1'b0;
    tick();
    chk("lit_ready_after_rst", cmd_ready, 8'd1);

    // Write path then read back.
    do_write(3'd1, 8'h00);
    send_byte(8'h01);
    tick();
    chk("lit_read_lat2_valid", rsp_valid, 8'd1);
    chk("lit_read_lat2_data", rsp_data, 8'h00);
    rsp_ready = 1'b1; tick(); rsp_ready = 1'b0;

    // Read back-pressure.
    do_write(3'd0, 8'h05);
    send_byte(8'h00);
    tick();
    for (int i = 0; i < 10; i++) begin
      chk("lit_bp_valid", rsp_valid, 8'd1);
      chk("lit_bp_data", rsp_data, 8'h05);
      chk("lit_bp_ready", cmd_ready, 8'd0);
      tick();
    end
    rsp_ready = 1'b1; tick(); rsp_ready = 1'b0;
    chk("lit_bp_done", rsp_valid, 8'd0);

    // Reserved-bit error, then a normal read.
    send_byte(8'h48);
    repeat (3) tick();
    chk("lit_rsvd_err", err_count, 8'd1);
    chk("lit_rsvd_norsp", rsp_valid, 8'd0);
    send_byte(8'h01);
    get_rsp("lit_read_after_err", 8'h00);

    // Data timeout, then a normal write and read.
    send_byte(8'h80);
    repeat (12) tick();
    chk("lit_timeout_err", err_count, 8'd2);
    do_write(3'd0, 8'h03);
    send_byte(8'h00);
    get_rsp("lit_palette3", 8'h03);

    // Reset mid-write: the next 0x01 is a read header, reg 1 stays 0x00.
    send_byte(8'h81);
    tick();
    rst = 1'b1; tick(); tick(); rst = 1'b0;
    chk("lit_midrst_err", err_count, 8'd0);
    send_byte(8'h01);
    get_rsp("lit_midrst_read", 8'h00);

    // Randomized traffic with occasional resets.
    for (int c = 0; c < 4000; c++) begin
      if (c % 100 == 0) begin
        case ($urandom_range(0, 2))
          0: pv = 10;
          1: pv = 50;
          default: pv = 90;
        endcase
      end
      rst       = ($urandom_range(0, 299) == 0);
      cmd_valid = ($urandom_range(0, 99) < pv);
      if ($urandom_range(0, 7) == 0) cmd_data = 8'($urandom);
      else cmd_data = {1'($urandom), 4'b0, 3'($urandom)};
      rsp_ready = 1'($urandom);
      tick();
    end
    rst = 1'b0; cmd_valid = 1'b0; rsp_ready = 1'b1;
    repeat (20) tick();
    rsp_ready = 1'b0;

    // Error counter saturation.
    for (int i = 0; i < 260; i++) send_byte(8'h48);
    tick();
    chk("lit_err_saturate", err_count, 8'hFF);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, misses);
    $finish;
  end

endmodule
